// File: rtl/keypad_entry_ctrl.sv
// 4x4 matrix keypad scanner with debounce/lockout FSM, an NUM_DIGITS-deep
// key history and a time-multiplexed digit display feed.
module keypad_entry_ctrl #(
   parameter int NUM_DIGITS      = 2,
   parameter int SCAN_CYCLES     = 12,
   parameter int DEBOUNCE_CYCLES = 400000,
   parameter int REFRESH_CYCLES  = 96000
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [3:0]            rows_n,
   output logic [3:0]            cols_n,
   output logic                  key_valid,
   output logic [3:0]            key_code,
   output logic [NUM_DIGITS-1:0] digit_sel,
   output logic [3:0]            digit_hex,
   output logic                  digit_blank
);

   localparam int SCW  = $clog2(SCAN_CYCLES);
   localparam int DBW  = $clog2(DEBOUNCE_CYCLES);
   localparam int RFW  = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
   localparam int IDXW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

   localparam logic [SCW-1:0]  SCAN_LAST = SCW'(SCAN_CYCLES - 1);
   localparam logic [DBW-1:0]  DB_LAST   = DBW'(DEBOUNCE_CYCLES - 1);
   localparam logic [RFW-1:0]  RF_LAST   = RFW'(REFRESH_CYCLES - 1);
   localparam logic [IDXW-1:0] IDX_LAST  = IDXW'(NUM_DIGITS - 1);

   typedef enum logic [1:0] {
      ST_SCAN,
      ST_PRESS_WAIT,
      ST_HELD,
      ST_RELEASE_WAIT
   } state_t;

   logic [3:0]            rows_meta_reg;
   logic [3:0]            rows_sync_reg;
   state_t                state_reg, state_next;
   logic [1:0]            col_idx_reg, col_idx_next;
   logic [1:0]            row_idx_reg, row_idx_next;
   logic [SCW-1:0]        scan_cnt_reg, scan_cnt_next;
   logic [DBW-1:0]        db_cnt_reg, db_cnt_next;
   logic [3:0]            cols_n_reg;
   logic                  key_valid_reg;
   logic [3:0]            key_code_reg, key_code_next;
   logic                  accept;
   logic [3:0]            hist_reg  [NUM_DIGITS];
   logic [3:0]            hist_next [NUM_DIGITS];
   logic [NUM_DIGITS-1:0] filled_reg, filled_next;
   logic [RFW-1:0]        ref_cnt_reg, ref_cnt_next;
   logic [IDXW-1:0]       dig_idx_reg, dig_idx_next;
   logic [NUM_DIGITS-1:0] digit_sel_reg;
   logic [3:0]            digit_hex_reg;
   logic                  digit_blank_reg;

   logic [3:0]            rows_down;
   logic                  single_down;
   logic [1:0]            single_row;
   logic                  captured_down;
   logic                  others_down;

   function automatic logic [3:0] key_map(input logic [1:0] row, input logic [1:0] col);
      logic [3:0] code;
      case ({row, col})
         4'h0:    code = 4'h1;
         4'h1:    code = 4'h2;
         4'h2:    code = 4'h3;
         4'h3:    code = 4'hA;
         4'h4:    code = 4'h4;
         4'h5:    code = 4'h5;
         4'h6:    code = 4'h6;
         4'h7:    code = 4'hB;
         4'h8:    code = 4'h7;
         4'h9:    code = 4'h8;
         4'hA:    code = 4'h9;
         4'hB:    code = 4'hC;
         4'hC:    code = 4'hE;
         4'hD:    code = 4'h0;
         4'hE:    code = 4'hF;
         default: code = 4'hD;
      endcase
      return code;
   endfunction

   assign rows_down     = ~rows_sync_reg;
   assign captured_down = rows_down[row_idx_reg];
   assign others_down   = |(rows_down & ~(4'b0001 << row_idx_reg));

   always_comb begin
      single_down = 1'b0;
      single_row  = 2'd0;
      case (rows_down)
         4'b0001: begin single_down = 1'b1; single_row = 2'd0; end
         4'b0010: begin single_down = 1'b1; single_row = 2'd1; end
         4'b0100: begin single_down = 1'b1; single_row = 2'd2; end
         4'b1000: begin single_down = 1'b1; single_row = 2'd3; end
         default: begin single_down = 1'b0; single_row = 2'd0; end
      endcase
   end

   // Keypad FSM: the column is frozen outside SCAN so the captured key stays observable.
   always_comb begin
      state_next    = state_reg;
      col_idx_next  = col_idx_reg;
      row_idx_next  = row_idx_reg;
      scan_cnt_next = scan_cnt_reg;
      db_cnt_next   = db_cnt_reg;
      key_code_next = key_code_reg;
      accept        = 1'b0;
      case (state_reg)
         ST_SCAN: begin
            if (scan_cnt_reg == SCAN_LAST) begin
               scan_cnt_next = '0;
               if (single_down) begin
                  row_idx_next = single_row;
                  db_cnt_next  = '0;
                  state_next   = ST_PRESS_WAIT;
               end else begin
                  col_idx_next = col_idx_reg + 2'd1;
               end
            end else begin
               scan_cnt_next = scan_cnt_reg + SCW'(1);
            end
         end
         ST_PRESS_WAIT: begin
            if (captured_down && !others_down) begin
               if (db_cnt_reg == DB_LAST) begin
                  accept        = 1'b1;
                  key_code_next = key_map(row_idx_reg, col_idx_reg);
                  state_next    = ST_HELD;
               end else begin
                  db_cnt_next = db_cnt_reg + DBW'(1);
               end
            end else begin
               state_next    = ST_SCAN;
               col_idx_next  = col_idx_reg + 2'd1;
               scan_cnt_next = '0;
            end
         end
         ST_HELD: begin
            if (!captured_down) begin
               db_cnt_next = '0;
               state_next  = ST_RELEASE_WAIT;
            end
         end
         ST_RELEASE_WAIT: begin
            if (captured_down) begin
               state_next = ST_HELD;
            end else if (db_cnt_reg == DB_LAST) begin
               state_next    = ST_SCAN;
               col_idx_next  = col_idx_reg + 2'd1;
               scan_cnt_next = '0;
            end else begin
               db_cnt_next = db_cnt_reg + DBW'(1);
            end
         end
         default: begin
            state_next = ST_SCAN;
         end
      endcase
   end

   // History shift: entry 0 takes the new code, older entries move up one slot.
   assign hist_next[0]   = accept ? key_code_next : hist_reg[0];
   assign filled_next[0] = filled_reg[0] | accept;

   generate
      for (genvar gi = 1; gi < NUM_DIGITS; gi++) begin : g_hist_shift
         assign hist_next[gi]   = accept ? hist_reg[gi-1]   : hist_reg[gi];
         assign filled_next[gi] = accept ? filled_reg[gi-1] : filled_reg[gi];
      end
   endgenerate

   always_comb begin
      ref_cnt_next = ref_cnt_reg + RFW'(1);
      dig_idx_next = dig_idx_reg;
      if (ref_cnt_reg == RF_LAST) begin
         ref_cnt_next = '0;
         dig_idx_next = (dig_idx_reg == IDX_LAST) ? '0 : dig_idx_reg + IDXW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rows_meta_reg   <= 4'hF;
         rows_sync_reg   <= 4'hF;
         state_reg       <= ST_SCAN;
         col_idx_reg     <= 2'd0;
         row_idx_reg     <= 2'd0;
         scan_cnt_reg    <= '0;
         db_cnt_reg      <= '0;
         cols_n_reg      <= 4'b1110;
         key_valid_reg   <= 1'b0;
         key_code_reg    <= 4'h0;
         filled_reg      <= '0;
         ref_cnt_reg     <= '0;
         dig_idx_reg     <= '0;
         digit_sel_reg   <= NUM_DIGITS'(1);
         digit_hex_reg   <= 4'h0;
         digit_blank_reg <= 1'b1;
      end else begin
         rows_meta_reg   <= rows_n;
         rows_sync_reg   <= rows_meta_reg;
         state_reg       <= state_next;
         col_idx_reg     <= col_idx_next;
         row_idx_reg     <= row_idx_next;
         scan_cnt_reg    <= scan_cnt_next;
         db_cnt_reg      <= db_cnt_next;
         cols_n_reg      <= ~(4'b0001 << col_idx_reg);
         key_valid_reg   <= accept;
         key_code_reg    <= key_code_next;
         filled_reg      <= filled_next;
         ref_cnt_reg     <= ref_cnt_next;
         dig_idx_reg     <= dig_idx_next;
         // Display registers look at the post-update history so a new key shows immediately.
         digit_sel_reg   <= NUM_DIGITS'(1) << dig_idx_next;
         digit_hex_reg   <= hist_next[dig_idx_next];
         digit_blank_reg <= ~filled_next[dig_idx_next];
      end
   end

   generate
      for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_hist_reg
         always_ff @(posedge clk) begin
            if (reset) begin
               hist_reg[gi] <= 4'h0;
            end else begin
               hist_reg[gi] <= hist_next[gi];
            end
         end
      end
   endgenerate

   assign cols_n      = cols_n_reg;
   assign key_valid   = key_valid_reg;
   assign key_code    = key_code_reg;
   assign digit_sel   = digit_sel_reg;
   assign digit_hex   = digit_hex_reg;
   assign digit_blank = digit_blank_reg;

endmodule

// File: tb/tb_keypad_entry_ctrl.sv
// Scoreboard bench: two controllers (2 and 4 digits) share one simulated keypad matrix;
// expected key codes are queued at stimulus time and checked by an independent monitor.
module tb_keypad_entry_ctrl;
   localparam int SC  = 4;
   localparam int DB  = 20;
   localparam int RC  = 4;
   localparam int GAP = 2 * DB + 4 * SC + 10;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [15:0] press_bits = '0;   // bit r*4+c set while key (row r, col c) is held
   logic [3:0]  rows_n_a, rows_n_b, cols_n_a, cols_n_b;
   logic        kv_a, kv_b, blank_a, blank_b;
   logic [3:0]  kc_a, kc_b, hex_a, hex_b;
   logic [1:0]  sel_a;
   logic [3:0]  sel_b;

   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;

   logic [3:0] key_tab [16] = '{4'h1, 4'h2, 4'h3, 4'hA,
                                4'h4, 4'h5, 4'h6, 4'hB,
                                4'h7, 4'h8, 4'h9, 4'hC,
                                4'hE, 4'h0, 4'hF, 4'hD};
   logic [3:0] exp_q_a [$];
   logic [3:0] exp_q_b [$];
   logic [3:0] hist_m   [2][4];
   logic       filled_m [2][4];
   logic [3:0] last_code [2];
   logic       kv_prev [2];

   always #5 clk = ~clk;

   // A row reads low when a held key sits on a currently driven column.
   always_comb begin
      for (int r = 0; r < 4; r++) begin
         rows_n_a[r] = ~|(press_bits[r*4 +: 4] & ~cols_n_a);
         rows_n_b[r] = ~|(press_bits[r*4 +: 4] & ~cols_n_b);
      end
   end

   keypad_entry_ctrl #(.NUM_DIGITS(2), .SCAN_CYCLES(SC), .DEBOUNCE_CYCLES(DB), .REFRESH_CYCLES(RC)) dut_a (
      .clk(clk), .reset(reset), .rows_n(rows_n_a), .cols_n(cols_n_a), .key_valid(kv_a),
      .key_code(kc_a), .digit_sel(sel_a), .digit_hex(hex_a), .digit_blank(blank_a));

   keypad_entry_ctrl #(.NUM_DIGITS(4), .SCAN_CYCLES(SC), .DEBOUNCE_CYCLES(DB), .REFRESH_CYCLES(RC)) dut_b (
      .clk(clk), .reset(reset), .rows_n(rows_n_b), .cols_n(cols_n_b), .key_valid(kv_b),
      .key_code(kc_b), .digit_sel(sel_b), .digit_hex(hex_b), .digit_blank(blank_b));

   task automatic check(input string name, input int act, input int req, input int d);
      vectors++;
      if (act != req) begin
         miscompares++;
         $display("FAIL %s dut%0d @%0t: got %0h, expected %0h", name, d, $time, act, req);
      end
   endtask

   task automatic mon_dut(input int d, input int nd, input logic kv, input logic [3:0] kc,
                          input logic [3:0] sel, input logic [3:0] hex, input logic blank,
                          input logic [3:0] cols);
      int         idx;
      logic [3:0] e;
      bit         have;
      have = 0;
      e = 4'h0;
      if (kv) begin
         if (d == 0 && exp_q_a.size() > 0) begin e = exp_q_a.pop_front(); have = 1; end
         else if (d == 1 && exp_q_b.size() > 0) begin e = exp_q_b.pop_front(); have = 1; end
         if (!have) begin
            check("unexpected_key_valid", int'(kv), 0, d);
         end else begin
            check("key_code", int'(kc), int'(e), d);
            for (int i = nd - 1; i > 0; i--) begin
               hist_m[d][i]   = hist_m[d][i-1];
               filled_m[d][i] = filled_m[d][i-1];
            end
            hist_m[d][0]   = e;
            filled_m[d][0] = 1'b1;
            last_code[d]   = e;
         end
         if (kv_prev[d]) check("key_valid_width", int'(kv), 0, d);
      end
      kv_prev[d] = kv;
      check("key_code_hold", int'(kc), int'(last_code[d]), d);
      idx = (cyc / RC) % nd;
      check("digit_sel", int'(sel), 1 << idx, d);
      check("digit_hex", int'(hex), int'(hist_m[d][idx]), d);
      check("digit_blank", int'(blank), filled_m[d][idx] ? 0 : 1, d);
      check("cols_onehot", $countones(~cols), 1, d);
   endtask

   // Monitor: samples 1 time unit after each rising edge.
   always @(posedge clk) begin
      #1;
      if (reset) begin
         cyc = 0;
         for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 4; i++) begin
               hist_m[d][i]   = 4'h0;
               filled_m[d][i] = 1'b0;
            end
            last_code[d] = 4'h0;
            kv_prev[d]   = 1'b0;
         end
         check("rst_cols_n", int'(cols_n_a), 4'b1110, 0);
         check("rst_key_valid", int'(kv_a), 0, 0);
         check("rst_key_code", int'(kc_a), 0, 0);
         check("rst_digit_sel", int'(sel_a), 1, 0);
         check("rst_digit_hex", int'(hex_a), 0, 0);
         check("rst_digit_blank", int'(blank_a), 1, 0);
         check("rst_cols_n", int'(cols_n_b), 4'b1110, 1);
         check("rst_key_valid", int'(kv_b), 0, 1);
         check("rst_digit_sel", int'(sel_b), 1, 1);
         check("rst_digit_blank", int'(blank_b), 1, 1);
      end else begin
         cyc++;
         mon_dut(0, 2, kv_a, kc_a, {2'b00, sel_a}, hex_a, blank_a, cols_n_a);
         mon_dut(1, 4, kv_b, kc_b, sel_b, hex_b, blank_b, cols_n_b);
      end
   end

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic set_key(input int r, input int c, input bit v);
      press_bits[r*4 + c] = v;
   endtask

   task automatic push(input int r, input int c);
      exp_q_a.push_back(key_tab[r*4 + c]);
      exp_q_b.push_back(key_tab[r*4 + c]);
   endtask

   task automatic check_drained();
      check("accept_pending", exp_q_a.size(), 0, 0);
      check("accept_pending", exp_q_b.size(), 0, 1);
      exp_q_a.delete();
      exp_q_b.delete();
   endtask

   task automatic press_key(input int r, input int c, input int hold);
      set_key(r, c, 1'b1);
      push(r, c);
      cycles(hold);
      check_drained();
      set_key(r, c, 1'b0);
      cycles(GAP);
   endtask

   task automatic bounce(input int r, input int c, input int n);
      for (int i = 0; i < n; i++) begin
         set_key(r, c, 1'b1);
         cycles($urandom_range(12, 3));
         set_key(r, c, 1'b0);
         cycles($urandom_range(12, 3));
      end
   endtask

   initial begin
      int r1, r2, c;
      cycles(2);
      reset = 1'b0;
      // reset values and display rotation
      cycles(6 * RC);
      // single press of '5'
      press_key(1, 1, 100);
      // press bounce, then stable press with release bounce
      for (int i = 0; i < 4; i++) begin
         set_key(1, 1, 1'b1); cycles(10);
         set_key(1, 1, 1'b0); cycles(10);
      end
      cycles(30);
      check_drained();
      set_key(1, 1, 1'b1);
      push(1, 1);
      cycles(60);
      for (int i = 0; i < 2; i++) begin
         set_key(1, 1, 1'b0); cycles(10);
         set_key(1, 1, 1'b1); cycles(10);
      end
      set_key(1, 1, 1'b0);
      cycles(GAP);
      check_drained();
      // lockout: extra keys while '5' is held
      set_key(1, 1, 1'b1);
      push(1, 1);
      cycles(60);
      set_key(0, 0, 1'b1);
      set_key(0, 1, 1'b1);
      cycles(40);
      set_key(0, 0, 1'b0);
      set_key(0, 1, 1'b0);
      cycles(5);
      set_key(1, 1, 1'b0);
      cycles(GAP);
      check_drained();
      // two rows down in one column
      c  = $urandom_range(3, 0);
      r1 = $urandom_range(3, 0);
      r2 = (r1 + $urandom_range(3, 1)) % 4;
      set_key(r1, c, 1'b1);
      set_key(r2, c, 1'b1);
      cycles(80);
      set_key(r1, c, 1'b0);
      set_key(r2, c, 1'b0);
      cycles(40);
      check_drained();
      // history wrap: 1 2 3 then A 0 F D E
      press_key(0, 0, 70);
      press_key(0, 1, 70);
      press_key(0, 2, 70);
      press_key(0, 3, 70);
      press_key(3, 1, 70);
      press_key(3, 2, 70);
      press_key(3, 3, 70);
      press_key(3, 0, 70);
      // reset during PRESS_WAIT (column 0 is driven straight out of reset)
      reset = 1'b1;
      set_key($urandom_range(3, 0), 0, 1'b1);
      cycles(2);
      reset = 1'b0;
      cycles(12);
      reset = 1'b1;
      press_bits = '0;
      cycles(2);
      reset = 1'b0;
      cycles(60);
      check_drained();
      // reset during HELD
      set_key(2, 1, 1'b1);
      push(2, 1);
      cycles(55);
      check_drained();
      reset = 1'b1;
      press_bits = '0;
      cycles(2);
      reset = 1'b0;
      cycles(60);
      check_drained();
      // randomized presses interleaved with sub-debounce bursts
      repeat (14) begin
         if ($urandom_range(2, 0) == 0) begin
            bounce($urandom_range(3, 0), $urandom_range(3, 0), $urandom_range(4, 1));
            cycles(30);
            check_drained();
         end
         press_key($urandom_range(3, 0), $urandom_range(3, 0), $urandom_range(100, 60));
      end
      check_drained();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/keypad_entry_ctrl.md
# keypad_entry_ctrl

Parametrised keypad-entry and multi-digit display controller for the 4x4 matrix keypad. It scans columns and synchronises the row inputs. A debounce FSM with press/release lockout runs on the single 48 MHz `clk`, replacing free-running divided clocks. Accepted keys go into an `NUM_DIGITS`-deep history that is time-multiplexed onto the common-segment display. `digit_hex` feeds the existing hex-to-seven-segment decoder.

## Interface
- `NUM_DIGITS`, default 2: number of stored and displayed digits (≥1).
- `SCAN_CYCLES`, default 12: `clk` cycles each column is driven while scanning (≥4).
- `DEBOUNCE_CYCLES`, default 400000: consecutive stable cycles required to accept a press or a release (≥2).
- `REFRESH_CYCLES`, default 96000: `clk` cycles each digit is displayed.
- `clk` input 1: 48 MHz system clock. One clock domain.
- `reset` input 1: synchronous, active-high.
- `rows_n` input 4: keypad rows, active-low, asynchronous, externally pulled up.
- `cols_n` output 4: column drive, one-hot active-low.
- `key_valid` output 1: one-cycle pulse per accepted key.
- `key_code` output 4: hex code of the last accepted key.
- `digit_sel` output `NUM_DIGITS`: one-hot active-high enable of the currently displayed digit.
- `digit_hex` output 4: value for the selected digit.
- `digit_blank` output 1: high when the selected digit has not been entered since reset.

## Operation
- **Row synchronisation.** `rows_n` passes through a 2-flop synchroniser; all logic uses the synchronised rows. A key is "down" when its row bit is 0.
- **Key map**, `code[row][col]`:
  - row0: 1 2 3 A
  - row1: 4 5 6 B
  - row2: 7 8 9 C
  - row3: E 0 F D
- **SCAN state.**
  - The column counter rotates col0→col3→col0, advancing every `SCAN_CYCLES`.
  - Rows are sampled in the last cycle of each column period.
  - Exactly one row down: capture (row, col), hold the column, clear the counter, go to PRESS_WAIT.
  - Zero rows down, or more than one: keep scanning.
- **PRESS_WAIT state.**
  - The captured row is down and no other row is down: increment the counter.
  - Counter reaches `DEBOUNCE_CYCLES`-1: pulse `key_valid`, load `key_code`, push into history, go to HELD.
  - Any mismatch: return to SCAN, advancing to the next column.
- **HELD state.**
  - The column stays held. Every other key is ignored (lockout), so a long hold produces exactly one `key_valid`.
  - The captured row goes up: clear the counter, go to RELEASE_WAIT.
- **RELEASE_WAIT state.**
  - The captured row stays up: count.
  - The row goes down again: back to HELD, with no new key.
  - Counter reaches `DEBOUNCE_CYCLES`-1: go to SCAN at the next column.
- **History.**
  - `NUM_DIGITS` x 4-bit shift register; entry 0 is the newest.
  - On accept: entry i+1 ← entry i, entry 0 ← code, and the oldest entry is discarded.
  - A `filled` mask shifts in a 1 alongside.
- **Display.**
  - The refresh counter advances the digit index every `REFRESH_CYCLES`, wrapping from `NUM_DIGITS`-1 to 0.
  - `digit_sel` = 1 << index.
  - `digit_hex` = history[index].
  - `digit_blank` = ~filled[index].
  - The display runs independently of keypad state.
- **Reset values** (reset at any time, including mid-debounce, fully reinitialises; no pulse is emitted):
  - state = SCAN
  - `cols_n` = 4'b1110
  - all counters = 0
  - history = 0, `filled` = 0
  - `key_valid` = 0, `key_code` = 0
  - `digit_sel` = 1, `digit_hex` = 0, `digit_blank` = 1

## Timing
- All outputs are registered.
- `cols_n` changes one cycle after the column counter wraps.
- Press acceptance:
  - Rows pass the 2-cycle synchroniser.
  - PRESS_WAIT is entered on the edge after the sample cycle.
  - `key_valid` asserts `DEBOUNCE_CYCLES` cycles after entry when the key is stable.
  - `key_valid` lasts exactly 1 cycle.
  - `key_code`, history and `filled` update on the same edge `key_valid` rises.
- The display update of a new digit is visible when that index is next selected, i.e. the same cycle if it is already selected.
- Minimum press-to-press interval: 2·`DEBOUNCE_CYCLES` + ≤4·`SCAN_CYCLES` + 3 cycles.
- Simultaneous events:
  - A reset asserted in the same cycle as an accept wins.
  - An accept and a refresh wrap in the same cycle both take effect.

## Test plan
1. **Reset.** Assert `reset` 2 cycles. Require `cols_n`=1110, `digit_sel`=01, `digit_blank`=1, `key_valid`=0, and `digit_sel` rotating every `REFRESH_CYCLES` (bench: `REFRESH_CYCLES`=4, `DEBOUNCE_CYCLES`=20, `SCAN_CYCLES`=4).
2. **Single press.** Hold row1 low only while col1 is driven, for 100 cycles. Require exactly one `key_valid` with `key_code`=5, history[0]=5, and `digit_blank`=0 on digit 0 and 1 on digit 1.
3. **Bounce.** Toggle row1 with 10-cycle pulses (< `DEBOUNCE_CYCLES`). Require no `key_valid` and scanning to resume. Then a stable press yields one pulse, and a release bounce of 10 cycles yields no extra pulse.
4. **Lockout / multi-key.**
   - Hold '5' and additionally press row0/col0: only code 5 is accepted.
   - Two rows down in one column during scan: no acceptance.
5. **History wrap** (`NUM_DIGITS`=2). Enter 1, then 2, then 3. Require history = {3,2}, digit_sel=01→`digit_hex`=3, digit_sel=10→`digit_hex`=2. Repeat with `NUM_DIGITS`=4 and codes A, 0, F, D, E.
6. **Reset mid-operation.** Assert `reset` during PRESS_WAIT, and again during HELD. Require no `key_valid`, all reset values restored, and a fresh press accepted normally afterward.
